// File: rtl/udp_payload_packer_if.sv
// udp_payload_packer_if: AXI-Stream style beat bundle (data/keep/valid/last/ready).
interface udp_payload_packer_if #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8
) ();
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, keep, valid, last, input ready);
    modport slave  (input data, keep, valid, last, output ready);
endinterface

// File: rtl/udp_payload_packer.sv
// udp_payload_packer: repacks low-justified variable-length payload beats into dense words.
// Optional statistics counters enabled by defining UDP_PAYLOAD_PACKER_STATS_EN.
module udp_payload_packer #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8,
    parameter int STAT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp_payload_packer_if.slave  s,
    udp_payload_packer_if.master m,
    output logic [STAT_W-1:0]    stat_pkts,
    output logic [STAT_W-1:0]    stat_bytes
);
    localparam int CW = $clog2(KEEP_W);
    localparam int RES_W = DATA_W - 8;
    localparam int MW = DATA_W + RES_W;
    localparam logic [CW:0] FULL = (CW+1)'(KEEP_W);

    typedef enum logic {PASS, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [KEEP_W-1:0] m_keep_q, m_keep_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0] sd;
    logic [MW-1:0]     merged;
    logic [CW:0]       n, c;
    logic              out_free, acc;

    function automatic logic [KEEP_W-1:0] keep_of(input logic [CW:0] k);
        return ~({KEEP_W{1'b1}} << k);
    endfunction

    // lanes above keep are zeroed so merged stays clean above c
    for (genvar i = 0; i < KEEP_W; i++) begin : g_mask
        assign sd[8*i +: 8] = s.data[8*i +: 8] & {8{s.keep[i]}};
    end

    assign out_free = !m_valid_q || m.ready;
    assign s.ready  = (state_q == PASS) && out_free;
    assign acc      = s.valid && s.ready;
    assign n        = (CW+1)'($countones(s.keep));
    assign c        = {1'b0, cnt_q} + n;
    assign merged   = {{DATA_W{1'b0}}, res_q} | ({{RES_W{1'b0}}, sd} << {cnt_q, 3'b000});

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_valid_d = m_valid_q && !m.ready;
        m_last_d  = m_last_q && m_valid_d;
        if (state_q == FLUSH) begin
            if (out_free) begin
                m_valid_d = 1'b1;
                m_data_d  = {8'd0, res_q};
                m_keep_d  = keep_of({1'b0, cnt_q});
                m_last_d  = 1'b1;
                res_d     = '0;
                cnt_d     = '0;
                state_d   = PASS;
            end
        end else if (acc) begin
            if (c >= FULL) begin
                m_valid_d = 1'b1;
                m_data_d  = merged[DATA_W-1:0];
                m_keep_d  = '1;
                m_last_d  = s.last && (c == FULL);
                res_d     = merged[MW-1:DATA_W];
                cnt_d     = CW'(c - FULL);
                state_d   = (s.last && c != FULL) ? FLUSH : PASS;
            end else if (s.last) begin
                if (c != '0) begin
                    m_valid_d = 1'b1;
                    m_data_d  = merged[DATA_W-1:0];
                    m_keep_d  = keep_of(c);
                    m_last_d  = 1'b1;
                end
                res_d = '0;
                cnt_d = '0;
            end else begin
                res_d = merged[RES_W-1:0];
                cnt_d = c[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PASS;
            res_q     <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m.data  = m_data_q;
    assign m.keep  = m_keep_q;
    assign m.valid = m_valid_q;
    assign m.last  = m_last_q;

`ifdef UDP_PAYLOAD_PACKER_STATS_EN
    logic [STAT_W-1:0] pkts_q, bytes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkts_q  <= '0;
            bytes_q <= '0;
        end else if (m_valid_q && m.ready) begin
            pkts_q  <= pkts_q + STAT_W'(m_last_q);
            bytes_q <= bytes_q + STAT_W'($countones(m_keep_q));
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_bytes = bytes_q;
`else
    assign stat_pkts  = '0;
    assign stat_bytes = '0;
`endif
endmodule

// File: tb/tb_udp_payload_packer.sv
// tb_udp_payload_packer: randomized scoreboard bench; expected beats come from chunking each packet's byte list.
module tb_udp_payload_packer;
    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_payload_packer_if s_if ();
    udp_payload_packer_if m_if ();
    logic [31:0] stat_pkts, stat_bytes;

    udp_payload_packer dut (
        .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if),
        .stat_pkts(stat_pkts), .stat_bytes(stat_bytes)
    );

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];
    int    pkt_n[$];
    int    rdy_mode = 0;
    int    exp_pkts = 0;
    int    exp_bytes = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    initial forever begin
        @(negedge clk);
        m_if.ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    initial begin
        beat_t        e;
        logic [255:0] hd;
        logic [31:0]  hk;
        logic         hl;
        logic         hold;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) hold = 1'b0;
            else begin
                if (hold) begin
                    check("hold_data", m_if.data, hd);
                    check("hold_keep", m_if.keep, hk);
                    check("hold_last", m_if.last, hl);
                end
                hold = 1'b0;
                if (m_if.valid && !m_if.ready) begin
                    hold = 1'b1;
                    hd = m_if.data;
                    hk = m_if.keep;
                    hl = m_if.last;
                    check("s_ready_stalled", s_if.ready, 0);
                end
                if (m_if.valid && m_if.ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got keep %h last %b, expected no beat", m_if.keep, m_if.last);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_if.data, e.d);
                        check("m_keep", m_if.keep, e.k);
                        check("m_last", m_if.last, e.l);
                    end
                end
            end
        end
    end

    task automatic send_pkt();
        logic [255:0]  bd[$];
        logic [31:0]   bk[$];
        byte unsigned  by[$];
        logic [255:0]  d;
        beat_t         b;
        int            n, t;
        foreach (pkt_n[i]) begin
            n = pkt_n[i];
            for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
            bd.push_back(d);
            bk.push_back(n == 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1);
            for (int j = 0; j < n; j++) by.push_back(d[8*j +: 8]);
        end
        for (int i = 0; i < by.size(); i += 32) begin
            int mb;
            mb = (by.size() - i < 32) ? by.size() - i : 32;
            b.d = '0;
            for (int j = 0; j < mb; j++) b.d[8*j +: 8] = by[i+j];
            b.k = (mb == 32) ? 32'hFFFF_FFFF : (32'd1 << mb) - 32'd1;
            b.l = (i + 32 >= by.size());
            exp_q.push_back(b);
        end
        if (by.size() > 0) exp_pkts++;
        exp_bytes += by.size();
        foreach (bd[i]) begin
            @(negedge clk);
            s_if.valid = 1'b1;
            s_if.data  = bd[i];
            s_if.keep  = bk[i];
            s_if.last  = (i == bd.size() - 1);
            #1;
            t = 0;
            while (!s_if.ready) begin
                @(negedge clk);
                #1;
                if (++t > 1000) begin
                    tests++;
                    fails++;
                    $display("FAIL s_ready_timeout: s_ready stuck at 0, expected 1 within 1000 cycles");
                    finish_tb();
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_pkts = 0;
        exp_bytes = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int st_p, st_b;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        m_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_if.valid, 0);
        check("rst_m_last", m_if.last, 0);
        check("rst_m_data", m_if.data, 0);
        check("rst_m_keep", m_if.keep, 0);
        check("rst_stat_pkts", stat_pkts, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pkt_n = '{22, 32, 10};
        send_pkt();
        drain();

        pkt_n = '{22, 32};
        send_pkt();
        #1;
        check("flush_s_ready_low", s_if.ready, 0);
        @(negedge clk);
        #1;
        check("flush_s_ready_back", s_if.ready, 1);
        drain();

        pkt_n = '{22};
        send_pkt();
        #1;
        check("latency_m_valid", m_if.valid, 1);
        drain();

        fork
            begin
                pkt_n = '{22, 32, 32, 32, 10};
                send_pkt();
            end
            begin
                repeat (3) @(negedge clk);
                rdy_mode = 2;
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        @(negedge clk);
        s_if.valid = 1'b1;
        s_if.data  = {8{$urandom}};
        s_if.keep  = 32'h003F_FFFF;
        s_if.last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_if.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_if.valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pkts = 0;
        exp_bytes = 0;
        pkt_n = '{22};
        send_pkt();
        drain();

        rdy_mode = 1;
        for (int p = 0; p < 150; p++) begin
            int nb;
            nb = $urandom_range(1, 5);
            pkt_n.delete();
            for (int q = 0; q < nb; q++)
                pkt_n.push_back((q == 0 && $urandom_range(0, 1) == 1) ? 22 : $urandom_range(0, 32));
            send_pkt();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rdy_mode = 0;
        repeat (2) @(negedge clk);
`ifdef UDP_PAYLOAD_PACKER_STATS_EN
        st_p = exp_pkts;
        st_b = exp_bytes;
`else
        st_p = 0;
        st_b = 0;
`endif
        check("rand_stat_pkts", stat_pkts, st_p);
        check("rand_stat_bytes", stat_bytes, st_b);

        do_reset();
        pkt_n = '{22};
        send_pkt();
        pkt_n = '{22, 32};
        send_pkt();
        pkt_n = '{22, 32, 10};
        send_pkt();
        drain();
`ifdef UDP_PAYLOAD_PACKER_STATS_EN
        st_p = 3;
        st_b = 140;
`else
        st_p = 0;
        st_b = 0;
`endif
        check("stat_pkts_3", stat_pkts, st_p);
        check("stat_bytes_140", stat_bytes, st_b);
        finish_tb();
    end
endmodule

// File: doc/udp_payload_packer.md
Name: udp_payload_packer

Overview:
- Sits directly downstream of the UDP header parser.
- Accepts a 256-bit AXI-Stream UDP payload whose beats carry low-justified, variable byte counts. The first beat is typically 22 bytes (keep 0x003FFFFF) after header stripping.
- Repacks the payload into dense 32-byte words, so that only the final beat of each packet is partial.
- Feeds the market-data message decoder, which relies on every non-last beat being fully populated.

Parameters:
- DATA_W, 256, stream data width in bits; multiple of 8.
- KEEP_W, DATA_W/8, byte-lane count (32).
- STAT_W, 32, width of the optional statistics counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  DATA_W  input payload; byte i at bits [8i+7:8i]
- s_keep  in  KEEP_W  input byte enables; must be low-contiguous (0, or 2^n-1)
- s_valid  in  1  input beat valid
- s_last  in  1  final beat of packet
- s_ready  out  1  block can accept the input beat
- m_data  out  DATA_W  packed output data
- m_keep  out  KEEP_W  output byte enables, always low-contiguous
- m_valid  out  1  output beat valid
- m_last  out  1  final output beat of packet
- m_ready  in  1  downstream accepts the beat
- stat_pkts  out  STAT_W  packets emitted (optional feature)
- stat_bytes  out  STAT_W  payload bytes emitted (optional feature)

Behaviour:
- Reset (async, active-low): m_valid=0, m_last=0, m_data=0, m_keep=0, res_cnt=0, state=PASS, stats=0. s_ready may go high one cycle after reset is released.
- Internal state:
  - residual register res_data, up to 31 bytes, low-justified;
  - res_cnt, 5 bits;
  - output register m_*.
- Handshakes:
  - Beat accepted when s_valid && s_ready.
  - Output transfer when m_valid && m_ready.
  - m_* hold stable while m_valid && !m_ready.
- s_ready = (state==PASS) && (!m_valid || m_ready). Combinational from registered state and m_ready only; no combinational path from s_valid.
- On an accepted beat:
  - n = popcount(s_keep), range 0..32; c = res_cnt + n, 6-bit.
  - merged = res_data | (s_data << 8*res_cnt). Use a 63-byte intermediate; no truncation before the split.
- State PASS, per accepted beat:
  - c<32, !s_last: no output; res_data=merged, res_cnt=c.
  - c>=32, !s_last: emit merged[255:0] with keep all-ones and last=0; res_data = merged bytes 32..c-1; res_cnt=c-32.
  - s_last, 1<=c<=32: emit merged low c bytes, keep=(1<<c)-1, last=1; res_cnt=0.
  - s_last, c>32: emit the full 32-byte word with last=0; move c-32 residual bytes into res_data; go to FLUSH.
  - s_last, c==0: packet is empty; nothing is emitted and stats are unchanged.
- State FLUSH:
  - s_ready=0.
  - When the output register is free, emit res_data with keep=(1<<res_cnt)-1 and last=1.
  - Then res_cnt=0 and state=PASS.
- Latency: one cycle from the accepting edge to m_valid. Full throughput of one beat/cycle is sustained except for a single FLUSH bubble on packets where c>32 at s_last.
- Bytes never reorder and never cross packet boundaries; residual is always 0 after each m_last.
- Bytes in m_data above the keep boundary are driven 0.
- Non-contiguous s_keep: undefined output. The block never deadlocks on it; popcount is still used.
- Reset asserted mid-packet: residual and any pending output are discarded, and no m_last is produced for that packet.

Optional Feature:
- Macro: UDP_PAYLOAD_PACKER_STATS_EN.
- Defined:
  - stat_pkts increments on each m_last transfer.
  - stat_bytes adds popcount(m_keep) on each output transfer.
  - Both wrap modulo 2^STAT_W and are cleared by rst_n.
- Undefined: stat_pkts and stat_bytes are tied to 0 and no counter logic is instantiated.

Test Plan:
- Beats keep 0x003FFFFF, 0xFFFFFFFF, 0x000003FF(last) with m_ready=1 -> 2 beats:
  - beat 1 = in0[0:21]+in1[0:9], keep 0xFFFFFFFF, last=0;
  - beat 2 = in1[10:31]+in2[0:9], keep 0xFFFFFFFF, last=1.
- Beats keep 0x003FFFFF, 0xFFFFFFFF(last) -> full word, then FLUSH beat keep 0x003FFFFF last=1; s_ready=0 for exactly 1 cycle.
- Single beat keep 0x003FFFFF last=1 -> one output beat one cycle later, keep 0x003FFFFF, last=1, m_data[255:176]=0.
- Hold m_ready=0 for 5 cycles mid-packet -> m_data/m_keep/m_last stable, s_ready=0, no bytes lost or duplicated once released.
- rst_n pulsed low after the first beat of a packet, then a fresh 22-byte packet -> only the fresh packet appears (keep 0x003FFFFF, last=1).
- With UDP_PAYLOAD_PACKER_STATS_EN, send 3 packets of 22, 54 and 64 bytes -> stat_pkts=3, stat_bytes=140.
